// File: rtl/key_detect_module.sv
// key_detect_module
//   Debounced push-button input stage. The raw active-low key passes through
//   a two-flop synchroniser and a four-state debounce FSM. The FSM produces a
//   clean pressed level plus one-cycle press, release and long-press pulses.
//
// Ports
//   CLK          in   system clock (50 MHz)
//   RSTn         in   asynchronous active-low reset
//   Key_In       in   raw key, active-low, asynchronous to CLK, may bounce
//   Key_Level    out  debounced key state, 1 = pressed
//   Key_Press    out  one-cycle pulse on accepted press
//   Key_Release  out  one-cycle pulse on accepted release
//   Key_Long     out  one-cycle pulse, at most once per press, after LONG held cycles
//
// State table
//   state      | meaning
//   IDLE       | key released and stable, waiting for a low sample
//   PRESS_DB   | key seen low, counting stable low samples
//   HELD       | press accepted, counting toward long-press
//   RELEASE_DB | key seen high while held, counting stable high samples

module key_detect_module #(
  parameter logic [25:0] DEBOUNCE = 26'd499_999,
  parameter logic [25:0] LONG     = 26'd49_999_999
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Key_In,
  output logic Key_Level,
  output logic Key_Press,
  output logic Key_Release,
  output logic Key_Long
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  logic        r_s1;
  logic        r_s2;
  state_t      r_state;
  logic [25:0] r_cnt;
  logic        r_long_done;
  logic        r_level;
  logic        r_press;
  logic        r_release;
  logic        r_long;

  state_t      w_state_nxt;
  logic [25:0] w_cnt_nxt;
  logic        w_long_done_nxt;
  logic        w_level_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_long_nxt;

  // Synchronisers reset to 1 (released) so a key held through reset is
  // seen as a fresh high->low transition and fully debounced.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= 26'd0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_s1        <= Key_In;
      r_s2        <= r_s1;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_long_done <= w_long_done_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!r_s2) w_state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (r_s2)                  w_state_nxt = IDLE;
        else if (r_cnt == DEBOUNCE) w_state_nxt = HELD;
      end
      HELD: begin
        if (r_s2) w_state_nxt = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (!r_s2)                 w_state_nxt = HELD;
        else if (r_cnt == DEBOUNCE) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_long_done_nxt = r_long_done;
    w_level_nxt     = r_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_s2) w_cnt_nxt = 26'd0;
      end
      PRESS_DB: begin
        if (r_s2) begin
          w_cnt_nxt = 26'd0;
        end else if (r_cnt == DEBOUNCE) begin
          w_cnt_nxt   = 26'd0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end
      HELD: begin
        // Counter freezes once the long pulse has fired, so it cannot wrap.
        if (r_s2) begin
          w_cnt_nxt = 26'd0;
        end else if (!r_long_done && (r_cnt == LONG)) begin
          w_long_nxt      = 1'b1;
          w_long_done_nxt = 1'b1;
        end else if (!r_long_done) begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end
      RELEASE_DB: begin
        // A bounce back to low keeps long_done, so Key_Long fires at most once.
        if (!r_s2) begin
          w_cnt_nxt = 26'd0;
        end else if (r_cnt == DEBOUNCE) begin
          w_cnt_nxt       = 26'd0;
          w_level_nxt     = 1'b0;
          w_release_nxt   = 1'b1;
          w_long_done_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end
      default: begin
        w_cnt_nxt       = 26'd0;
        w_long_done_nxt = 1'b0;
        w_level_nxt     = 1'b0;
      end
    endcase
  end

  assign Key_Level   = r_level;
  assign Key_Press   = r_press;
  assign Key_Release = r_release;
  assign Key_Long    = r_long;

endmodule
